decim_serial: RTL and testbench

Sequential, multi-channel binary-to-BCD converter for on-screen numeric fields such as option values, guess counters and hint counts. It converts CHANNELS unsigned values of W_IN bits each into DIGITS decimal digits per channel, using a shift-and-add-3 (double-dabble) datapath shared across all channels. It sits between the game-state registers and the text renderer. It replaces per-field combinational divide/modulo logic with one small iterative engine behind a start/done handshake.

---
 rtl/decim_serial.sv | 203 ++++++++++++++++++++
 tb/tb_decim_serial.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decim_serial.sv
// decim_serial: multi-channel binary-to-BCD converter built on one shared
// shift-and-add-3 (double-dabble) engine.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       conversion request (taken only while busy=0)
//   values_in   CHANNELS x W_IN packed unsigned inputs, channel c at [c*W_IN +: W_IN]
//   digits_out  CHANNELS x DIGITS BCD digits, channel c digit d at [(c*DIGITS+d)*4 +: 4]
//   ovf_out     per-channel flag, set when the value exceeds 10^DIGITS-1
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse in the cycle digits_out/ovf_out are first valid
//
// Handshake: start is sampled on a rising edge only while busy=0; that edge
// snapshots values_in and begins a conversion. Requests made while busy=1
// (including the done cycle) are dropped, never queued. done pulses once per
// accepted request, and the outputs hold until the next done.
//
// Optional build macro DECIM_SERIAL_LZ_BLANK_EN: leading zero digits (never
// digit 0) are replaced by 4'hF, the blank glyph code, on the way to digits_out.

module decim_serial #(
  parameter int W_IN     = 8,
  parameter int DIGITS   = 3,
  parameter int CHANNELS = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CHANNELS*W_IN-1:0]     values_in,
  output logic [CHANNELS*DIGITS*4-1:0] digits_out,
  output logic [CHANNELS-1:0]          ovf_out,
  output logic                         busy,
  output logic                         done
);

  localparam int DW   = DIGITS * 4;
  localparam int MW   = (W_IN > 14) ? W_IN : 14;
  localparam int CNTW = $clog2(W_IN);
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [MW-1:0]   MAX_VAL  = MW'(10 ** DIGITS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W_IN - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_q,   state_d;
  logic [CHANNELS*W_IN-1:0]     snap_q,    snap_d;
  logic [CHW-1:0]               ch_q,      ch_d;
  logic [DW-1:0]                acc_q,     acc_d;
  logic [W_IN-1:0]              sr_q,      sr_d;
  logic [CNTW-1:0]              cnt_q,     cnt_d;
  logic                         ovf_q,     ovf_d;
  logic [CHANNELS*DW-1:0]       res_dig_q, res_dig_d;
  logic [CHANNELS-1:0]          res_ovf_q, res_ovf_d;
  logic [CHANNELS*DW-1:0]       dig_out_q, dig_out_d;
  logic [CHANNELS-1:0]          ovf_out_q, ovf_out_d;
  logic                         busy_q,    busy_d;
  logic                         done_q,    done_d;

  logic [DW-1:0]                acc_adj;
  logic [W_IN-1:0]              cur_val;
  logic [CHANNELS*DW-1:0]       shown;

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[d*4 +: 4] >= 4'd5) begin
        acc_adj[d*4 +: 4] = acc_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
`ifdef DECIM_SERIAL_LZ_BLANK_EN
    logic lead;
    lead      = 1'b0;
`endif
    state_d   = state_q;
    snap_d    = snap_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_dig_d = res_dig_q;
    res_ovf_d = res_ovf_q;
    dig_out_d = dig_out_q;
    ovf_out_d = ovf_out_q;
    cur_val   = snap_q[int'(ch_q)*W_IN +: W_IN];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = values_in;
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        sr_d    = cur_val;
        cnt_d   = '0;
        // Sole overflow source: bits lost off the top digit while shifting
        // are deliberately ignored.
        ovf_d   = (MW'(cur_val) > MAX_VAL);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        cnt_d         = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        res_dig_d[int'(ch_q)*DW +: DW] = ovf_q ? {DIGITS{4'h9}} : acc_q;
        res_ovf_d[ch_q]                = ovf_q;
        if (ch_q == CH_LAST) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result buffers as they will be after this edge, so the last channel's
    // store lands in the outputs on the same edge that enters DONE.
    shown = res_dig_d;
`ifdef DECIM_SERIAL_LZ_BLANK_EN
    for (int c = 0; c < CHANNELS; c++) begin
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (lead && (shown[(c*DIGITS+d)*4 +: 4] == 4'd0)) begin
          shown[(c*DIGITS+d)*4 +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    if ((state_q == S_STORE) && (state_d == S_DONE)) begin
      dig_out_d = shown;
      ovf_out_d = res_ovf_d;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_dig_q <= '0;
      res_ovf_q <= '0;
      dig_out_q <= '0;
      ovf_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_dig_q <= res_dig_d;
      res_ovf_q <= res_ovf_d;
      dig_out_q <= dig_out_d;
      ovf_out_q <= ovf_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign digits_out = dig_out_q;
  assign ovf_out    = ovf_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_decim_serial.sv
// tb_decim_serial: directed bench for decim_serial. Two instances share clock,
// reset, start and values: u_d3 (W_IN=8, DIGITS=3, CHANNELS=2) and
// u_d2 (W_IN=8, DIGITS=2, CHANNELS=2). Values are packed {ch1, ch0}.

module tb_decim_serial;

`ifdef DECIM_SERIAL_LZ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [15:0] values_in;
  logic [23:0] dig3;
  logic [1:0]  ovf3;
  logic        busy3, done3;
  logic [15:0] dig2;
  logic [1:0]  ovf2;
  logic        busy2, done2;

  int vectors = 0;
  int errs    = 0;

  decim_serial #(.W_IN(8), .DIGITS(3), .CHANNELS(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start), .values_in(values_in),
    .digits_out(dig3), .ovf_out(ovf3), .busy(busy3), .done(done3)
  );

  decim_serial #(.W_IN(8), .DIGITS(2), .CHANNELS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .values_in(values_in),
    .digits_out(dig2), .ovf_out(ovf2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issues start with vals, then samples 50 cycles (#1 after each edge).
  // Expected profile: busy cycles 1..21, done in cycle 21; with hold, start
  // stays high so a second run is accepted at the end of idle cycle 22.
  task automatic run_conv(input logic [15:0] vals, input int restart_cyc,
                          input logic [15:0] alt, input bit hold,
                          output int first_done, output int second_done,
                          output int done_cnt, output int prof_bad);
    logic exp_busy, exp_done;
    values_in = vals;
    start     = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    first_done  = -1;
    second_done = -1;
    done_cnt    = 0;
    prof_bad    = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      exp_busy = (cyc <= 21) || (hold && cyc >= 23 && cyc <= 43);
      exp_done = (cyc == 21) || (hold && cyc == 43);
      if (busy3 !== exp_busy || busy2 !== exp_busy ||
          done3 !== exp_done || done2 !== exp_done) prof_bad++;
      if (done3 === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        else second_done = cyc;
      end
      if (cyc == restart_cyc) begin
        start     = 1'b1;
        values_in = alt;
      end
      if (cyc == restart_cyc + 1) start = 1'b0;
      if (hold && cyc == 23) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] e3, input logic [1:0] eo3,
                         input logic [15:0] e2, input logic [1:0] eo2);
    chk({tag, "_dig_d3"}, dig3, e3);
    chk({tag, "_ovf_d3"}, ovf3, eo3);
    chk({tag, "_dig_d2"}, dig2, e2);
    chk({tag, "_ovf_d2"}, ovf2, eo2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd, sd, dc, pb;
    rst_n     = 1'b0;
    start     = 1'b0;
    values_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dig_d3", dig3, 24'h0);
    chk("reset_ovf_d3", ovf3, 2'b00);
    chk("reset_busy",   {busy3, busy2}, 2'b00);
    chk("reset_done",   {done3, done2}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ch0=255, ch1=7
    run_conv({8'd7, 8'd255}, -1, 16'h0, 1'b0, fd, sd, dc, pb);
    chk("v1_done_cycle", fd, 21);
    chk("v1_profile",    pb, 0);
    chk_out("v1", BLANK ? 24'hFF7255 : 24'h007255, 2'b00,
                  BLANK ? 16'hF799   : 16'h0799,   2'b01);

    // ch0=0, ch1=99
    run_conv({8'd99, 8'd0}, -1, 16'h0, 1'b0, fd, sd, dc, pb);
    chk("v2_done_cycle", fd, 21);
    chk("v2_profile",    pb, 0);
    chk_out("v2", BLANK ? 24'hF99FF0 : 24'h099000, 2'b00,
                  BLANK ? 16'h99F0   : 16'h9900,   2'b00);

    // ch0=100 (overflows two digits), ch1=99 (fits)
    run_conv({8'd99, 8'd100}, -1, 16'h0, 1'b0, fd, sd, dc, pb);
    chk("v3_profile", pb, 0);
    chk_out("v3", BLANK ? 24'hF99100 : 24'h099100, 2'b00, 16'h9999, 2'b01);

    // snapshot {7,120}; start and new values {2,1} at cycle 5 are ignored
    run_conv({8'd7, 8'd120}, 5, {8'd2, 8'd1}, 1'b0, fd, sd, dc, pb);
    chk("v4_done_count", dc, 1);
    chk("v4_profile",    pb, 0);
    chk_out("v4", BLANK ? 24'hFF7120 : 24'h007120, 2'b00,
                  BLANK ? 16'hF799   : 16'h0799,   2'b01);

    // reset in cycle 10 of a running conversion
    values_in = {8'd50, 8'd200};
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("v5_busy_before_reset", busy3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("v5_rst_dig_d3", dig3, 24'h0);
    chk("v5_rst_dig_d2", dig2, 16'h0);
    chk("v5_rst_ovf",    {ovf3, ovf2}, 4'h0);
    chk("v5_rst_busy",   {busy3, busy2}, 2'b00);
    @(posedge clk); #1;
    chk("v5_rst_done",   {done3, done2}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv({8'd250, 8'd58}, -1, 16'h0, 1'b0, fd, sd, dc, pb);
    chk("v5_done_cycle", fd, 21);
    chk("v5_profile",    pb, 0);
    chk_out("v5", BLANK ? 24'h250F58 : 24'h250058, 2'b00, 16'h9958, 2'b10);

    // start held high: re-triggers on the first idle cycle
    run_conv({8'd10, 8'd9}, -1, 16'h0, 1'b1, fd, sd, dc, pb);
    chk("v6_done_count",  dc, 2);
    chk("v6_second_done", sd, 43);
    chk("v6_profile",     pb, 0);
    chk_out("v6", BLANK ? 24'hF10FF9 : 24'h010009, 2'b00,
                  BLANK ? 16'h10F9   : 16'h1009,   2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
